// File: rtl/co2_pkg.sv
// -----------------------------------------------------------------------------
// co2_pkg
// Shared definitions for the serial pattern transmitter and detector benches.
//   tx_state_e   : transmitter FSM states
//   CO2_PATTERN  : default 8-bit pattern used by both tx and detector benches
//   cnt_w()      : counter width helper, never returns less than 1
// -----------------------------------------------------------------------------
package co2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } tx_state_e;

    localparam logic [7:0] CO2_PATTERN = 8'b1011_0010;

    // clog2 that never yields a zero-width vector (e.g. GAP_BITS=0 -> 1 bit)
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/co2_pattern_tx_if.sv
// -----------------------------------------------------------------------------
// co2_pattern_tx_if
// Control/data bundle of the serial pattern transmitter.
//   master : frame requester (drives start/pattern_in/reps_in/bit_en/abort)
//   slave  : transmitter (drives dout/dout_valid/busy/done)
// -----------------------------------------------------------------------------
interface co2_pattern_tx_if #(
    parameter int PATTERN_W = 8,
    parameter int REPS_W    = 4
);
    logic                 start;
    logic [PATTERN_W-1:0] pattern_in;
    logic [REPS_W-1:0]    reps_in;
    logic                 bit_en;
    logic                 abort;
    logic                 dout;
    logic                 dout_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output start, pattern_in, reps_in, bit_en, abort,
        input  dout, dout_valid, busy, done
    );

    modport slave (
        input  start, pattern_in, reps_in, bit_en, abort,
        output dout, dout_valid, busy, done
    );
endinterface

// File: rtl/co2_bit_shifter.sv
// -----------------------------------------------------------------------------
// co2_bit_shifter
// PATTERN_W-bit load/shift register, MSB-first serial out.
//   load    : capture din into shadow word and working register
//   reload  : restore working register from shadow (next repetition);
//             wins over shift in the same cycle
//   shift   : advance working register by one bit
//   bit_idx : bit index currently presented (owned by the caller)
//   sout    : bit to transmit now (working register MSB)
//   last    : bit_idx addresses the final bit of the word
// -----------------------------------------------------------------------------
module co2_bit_shifter #(
    parameter int PATTERN_W = 8,
    parameter int BW        = 3
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 load,
    input  logic                 reload,
    input  logic                 shift,
    input  logic [PATTERN_W-1:0] din,
    input  logic [BW-1:0]        bit_idx,
    output logic                 sout,
    output logic                 last
);
    logic [PATTERN_W-1:0] shadow;
    logic [PATTERN_W-1:0] sr;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            shadow <= '0;
            sr     <= '0;
        end else if (load) begin
            shadow <= din;
            sr     <= din;
        end else if (reload) begin
            sr     <= shadow;
        end else if (shift) begin
            sr     <= {sr[PATTERN_W-2:0], 1'b0};
        end
    end

    assign sout = sr[PATTERN_W-1];
    assign last = (bit_idx == BW'(PATTERN_W - 1));
endmodule

// File: rtl/co2_pattern_tx.sv
// -----------------------------------------------------------------------------
// co2_pattern_tx
// Serial pattern transmitter: sends a PATTERN_W-bit word MSB-first, one bit
// per bit_en strobe, repeated reps_in times with GAP_BITS idle bit periods
// between repetitions.
//   clk, arst : clock (posedge), asynchronous active-low reset
//   bus       : slave side of co2_pattern_tx_if
//               start/pattern_in/reps_in : frame request, sampled in IDLE
//               bit_en                   : bit-period strobe
//               abort                    : cancel frame (SEND/GAP)
//               dout/dout_valid          : serial line and new-bit strobe
//               busy/done                : frame in progress / completion
// All outputs are registered. busy stays high through the done cycle so a
// requester sees busy fall only after done.
// -----------------------------------------------------------------------------
module co2_pattern_tx
    import co2_pkg::*;
#(
    parameter int PATTERN_W = 8,
    parameter int REPS_W    = 4,
    parameter int GAP_BITS  = 2
) (
    input  logic             clk,
    input  logic             arst,
    co2_pattern_tx_if.slave  bus
);
    localparam int BW = cnt_w(PATTERN_W);
    localparam int GW = cnt_w(GAP_BITS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    tx_state_e         state, state_d;
    logic [BW-1:0]     bitcnt, bitcnt_d;
    logic [REPS_W-1:0] rep_cnt, rep_d;
    logic [GW-1:0]     gap_cnt, gap_d;
    logic              dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              sh_load, sh_reload, sh_shift;
    logic              sh_sout, sh_last;

    co2_bit_shifter #(.PATTERN_W(PATTERN_W), .BW(BW)) u_shifter (
        .clk     (clk),
        .arst    (arst),
        .load    (sh_load),
        .reload  (sh_reload),
        .shift   (sh_shift),
        .din     (bus.pattern_in),
        .bit_idx (bitcnt),
        .sout    (sh_sout),
        .last    (sh_last)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state   <= IDLE;
            bitcnt  <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            bitcnt  <= bitcnt_d;
            rep_cnt <= rep_d;
            gap_cnt <= gap_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        bitcnt_d  = bitcnt;
        rep_d     = rep_cnt;
        gap_d     = gap_cnt;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sh_load   = 1'b0;
        sh_reload = 1'b0;
        sh_shift  = 1'b0;

        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                dout_d = 1'b0;
                // zero repetitions is not a frame: ignore the request entirely
                if (bus.start && bus.reps_in != '0) begin
                    sh_load  = 1'b1;
                    rep_d    = bus.reps_in;
                    bitcnt_d = '0;
                    gap_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    dout_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.bit_en) begin
                    dout_d   = sh_sout;
                    valid_d  = 1'b1;
                    sh_shift = 1'b1;
                    bitcnt_d = bitcnt + BW'(1);
                    if (sh_last) begin
                        bitcnt_d = '0;
                        // rep_cnt >= 1 while in SEND, so this never wraps
                        rep_d    = rep_cnt - REPS_W'(1);
                        if (rep_cnt > REPS_W'(1)) begin
                            if (GAP_BITS > 0) state_d = GAP;
                            else              sh_reload = 1'b1;
                        end else begin
                            state_d = FIN;
                        end
                    end
                end
            end
            GAP: begin
                dout_d = 1'b0;
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.bit_en) begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_d     = '0;
                        sh_reload = 1'b1;
                        state_d   = SEND;
                    end else begin
                        gap_d = gap_cnt + GW'(1);
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                dout_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
